// File: rtl/imm_gen_stage.sv
// imm_gen_stage: registered immediate-generation stage between fetch and decode.
//   Decodes the immediate of each accepted instruction/PC beat and buffers the
//   decoded result in a DEPTH-entry FIFO behind a valid/ready handshake.
//   Params : XLEN (32|64) datapath width, DEPTH (power of two, >=2) FIFO entries,
//            CW occupancy counter width (derived).
//   Ports  : clk, rst (async, active-high), flush (sync discard of all beats)
//            in_valid/in_ready/in_instr/in_pc            upstream beat
//            out_valid/out_ready/out_instr/out_pc        head beat
//            out_imm, out_imm_type (0 NONE,1 I,2 S,3 B,4 U,5 J,6 Z), out_illegal
//            occupancy                                   buffered beat count
//   Macro  : IMM_GEN_CSR_EN enables type Z (CSR immediate forms of SYSTEM).
module imm_gen_stage #(
    parameter int XLEN = 32,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_illegal,
    output logic [CW-1:0]   occupancy
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [2:0]      imm_type;
        logic            illegal;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          in_ent;
    entry_t          head;
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [6:0]      opcode;
    logic            is_i;
    logic            csr_z;
    logic [2:0]      imm_type;
    logic [XLEN-1:0] imm;
    logic            push;
    logic            pop;

    assign opcode = in_instr[6:0];
    // OP-IMM-32 only exists in RV64; in RV32 it falls through to NONE
    assign is_i = opcode == 7'b0000011 || opcode == 7'b0010011 || opcode == 7'b1100111 ||
                  (XLEN == 64 && opcode == 7'b0011011);
`ifdef IMM_GEN_CSR_EN
    assign csr_z = opcode == 7'b1110011 && in_instr[14];
`else
    assign csr_z = 1'b0;
`endif
    assign imm_type = is_i                     ? 3'd1 :
                      opcode == 7'b0100011     ? 3'd2 :
                      opcode == 7'b1100011     ? 3'd3 :
                      (opcode == 7'b0110111 || opcode == 7'b0010111) ? 3'd4 :
                      opcode == 7'b1101111     ? 3'd5 :
                      csr_z                    ? 3'd6 : 3'd0;

    // Signed casts to XLEN sign-extend each assembled field
    always_comb begin
        imm = '0;
        case (imm_type)
            3'd1: imm = XLEN'($signed(in_instr[31:20]));
            3'd2: imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
            3'd3: imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
            3'd4: imm = XLEN'($signed({in_instr[31:12], 12'h000}));
            3'd5: imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
            3'd6: imm = XLEN'(in_instr[19:15]);
            default: imm = '0;
        endcase
    end

    assign in_ent = '{instr: in_instr, pc: in_pc, imm: imm, imm_type: imm_type,
                      illegal: in_instr[1:0] != 2'b11};

    assign in_ready  = !rst && count != CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign occupancy = count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
        end
    end

    // Storage needs no reset: outputs are gated by out_valid
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= in_ent;
    end

    assign head         = mem[rd_ptr];
    assign out_instr    = out_valid ? head.instr : '0;
    assign out_pc       = out_valid ? head.pc : '0;
    assign out_imm      = out_valid ? head.imm : '0;
    assign out_imm_type = out_valid ? head.imm_type : '0;
    assign out_illegal  = out_valid ? head.illegal : 1'b0;
endmodule
